ysyx_23060191_trap_ctrl: RTL and testbench

YSYX_23060191_TRAP_CTRL -- requirements
Module: ysyx_23060191_trap_ctrl

---
 rtl/ysyx_23060191_trap_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_ysyx_23060191_trap_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060191_trap_ctrl.sv
// Trap/CSR sequencing controller: runs CSR read-modify-write, ECALL trap entry
// and MRET return as short fixed sequences against a single-port CSR file.
module ysyx_23060191_trap_ctrl #(
    parameter int          CPU_WIDTH = 32,
    parameter logic [11:0] MTVEC_A   = 12'h305,
    parameter logic [11:0] MEPC_A    = 12'h341,
    parameter logic [11:0] MCAUSE_A  = 12'h342
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_type,
    input  logic [1:0]           csr_op,
    input  logic [11:0]          csr_addr,
    input  logic [CPU_WIDTH-1:0] csr_src,
    input  logic [CPU_WIDTH-1:0] req_pc,
    input  logic [7:0]           ecall_no,
    output logic [11:0]          csr_raddr,
    input  logic [CPU_WIDTH-1:0] csr_rdata,
    output logic                 csr_we,
    output logic [11:0]          csr_waddr,
    output logic [CPU_WIDTH-1:0] csr_wdata,
    output logic                 rd_we,
    output logic [CPU_WIDTH-1:0] rd_data,
    output logic                 redirect_valid,
    output logic [CPU_WIDTH-1:0] redirect_pc,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CSR_RD   = 3'd1,
        CSR_WR   = 3'd2,
        TR_EPC   = 3'd3,
        TR_CAUSE = 3'd4,
        TR_VEC   = 3'd5,
        MRET     = 3'd6,
        ERR      = 3'd7
    } state_e;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    state_e                 state_q, state_d;
    logic [1:0]             op_q;
    logic [11:0]            addr_q;
    logic [CPU_WIDTH-1:0]   src_q;
    logic [CPU_WIDTH-1:0]   pc_q;
    logic [7:0]             ecall_q;
    logic [CPU_WIDTH-1:0]   old_q;
    logic                   accept_s;
    logic                   wr_skip_s;

    function automatic logic [CPU_WIDTH-1:0] csr_modify(
        input logic [1:0]           op,
        input logic [CPU_WIDTH-1:0] old_val,
        input logic [CPU_WIDTH-1:0] src
    );
        case (op)
            OP_RS:   csr_modify = old_val | src;
            OP_RC:   csr_modify = old_val & ~src;
            default: csr_modify = src;
        endcase
    endfunction

    assign accept_s  = (state_q == IDLE) && req_valid;
    // Set/clear with a zero mask must leave the CSR untouched (no side-effect write).
    assign wr_skip_s = (op_q != OP_RW) && (src_q == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch and old-CSR-value capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= 2'b00;
            addr_q  <= 12'h000;
            src_q   <= '0;
            pc_q    <= '0;
            ecall_q <= 8'h00;
            old_q   <= '0;
        end else begin
            if (accept_s) begin
                op_q    <= csr_op;
                addr_q  <= csr_addr;
                src_q   <= csr_src;
                pc_q    <= req_pc;
                ecall_q <= ecall_no;
            end
            if (state_q == CSR_RD) begin
                old_q <= csr_rdata;
            end
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    case (req_type)
                        2'b00:   state_d = (csr_op == 2'b00) ? ERR : CSR_RD;
                        2'b01:   state_d = TR_EPC;
                        2'b10:   state_d = MRET;
                        default: state_d = ERR;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            CSR_RD:   state_d = CSR_WR;
            CSR_WR:   state_d = IDLE;
            TR_EPC:   state_d = TR_CAUSE;
            TR_CAUSE: state_d = TR_VEC;
            TR_VEC:   state_d = IDLE;
            MRET:     state_d = IDLE;
            ERR:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output decode: every pulse and its payload come straight from the current state.
    always_comb begin
        req_ready      = 1'b0;
        csr_raddr      = 12'h000;
        csr_we         = 1'b0;
        csr_waddr      = 12'h000;
        csr_wdata      = '0;
        rd_we          = 1'b0;
        rd_data        = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        done           = 1'b0;
        err            = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
            end
            CSR_RD: begin
                csr_raddr = addr_q;
            end
            CSR_WR: begin
                if (wr_skip_s) begin
                    csr_we = 1'b0;
                end else begin
                    csr_we    = 1'b1;
                    csr_waddr = addr_q;
                    csr_wdata = csr_modify(op_q, old_q, src_q);
                end
                rd_we   = 1'b1;
                rd_data = old_q;
                done    = 1'b1;
            end
            TR_EPC: begin
                csr_we    = 1'b1;
                csr_waddr = MEPC_A;
                csr_wdata = pc_q;
            end
            TR_CAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = MCAUSE_A;
                csr_wdata = {{(CPU_WIDTH-8){1'b0}}, ecall_q};
            end
            TR_VEC: begin
                csr_raddr      = MTVEC_A;
                redirect_valid = 1'b1;
                redirect_pc    = {csr_rdata[CPU_WIDTH-1:2], 2'b00};
                done           = 1'b1;
            end
            MRET: begin
                csr_raddr      = MEPC_A;
                redirect_valid = 1'b1;
                redirect_pc    = csr_rdata;
                done           = 1'b1;
            end
            ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060191_trap_ctrl.sv
// Scoreboard bench for the trap controller: directed requests push expected
// output events; a negedge monitor pops and compares each DUT output event.
module tb_ysyx_23060191_trap_ctrl;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [1:0]     req_type = 2'b00;
    logic [1:0]     csr_op = 2'b00;
    logic [11:0]    csr_addr = 12'h000;
    logic [W-1:0]   csr_src = 32'h0;
    logic [W-1:0]   req_pc = 32'h0;
    logic [7:0]     ecall_no = 8'h00;
    logic [11:0]    csr_raddr;
    logic [W-1:0]   csr_rdata;
    logic           csr_we;
    logic [11:0]    csr_waddr;
    logic [W-1:0]   csr_wdata;
    logic           rd_we;
    logic [W-1:0]   rd_data;
    logic           redirect_valid;
    logic [W-1:0]   redirect_pc;
    logic           done;
    logic           err;

    ysyx_23060191_trap_ctrl #(.CPU_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_type(req_type), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_src(csr_src), .req_pc(req_pc), .ecall_no(ecall_no),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .rd_we(rd_we), .rd_data(rd_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // CSR file environment: combinational read, write on rising edge.
    logic [W-1:0] csr_mem [0:4095];
    assign csr_rdata = csr_mem[csr_raddr];

    initial begin
        for (int i = 0; i < 4096; i++) csr_mem[i] = 32'h0;
        csr_mem[12'h342] = 32'h0000_000B;
        forever begin
            @(posedge clk);
            if (csr_we) csr_mem[csr_waddr] <= csr_wdata;
        end
    end

    typedef struct packed {
        int          cyc;
        logic        we;
        logic [11:0] wa;
        logic [W-1:0] wd;
        logic        rdwe;
        logic [W-1:0] rdd;
        logic        rv;
        logic [W-1:0] rpc;
        logic        dn;
        logic        er;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    function automatic ev_t mk(input int c, input logic we, input logic [11:0] wa,
                               input logic [W-1:0] wd, input logic rdwe,
                               input logic [W-1:0] rdd, input logic rv,
                               input logic [W-1:0] rpc, input logic dn, input logic er);
        ev_t e;
        e.cyc = c; e.we = we; e.wa = wa; e.wd = wd; e.rdwe = rdwe;
        e.rdd = rdd; e.rv = rv; e.rpc = rpc; e.dn = dn; e.er = er;
        return e;
    endfunction

    // Monitor: every cycle with an output pulse must match the next expected event.
    initial begin : monitor
        ev_t e;
        ev_t a;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checks++;
                if (csr_we || rd_we || redirect_valid || done || err) begin
                    a = mk(cyc, csr_we, csr_waddr, csr_wdata, rd_we, rd_data,
                           redirect_valid, redirect_pc, done, err);
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_event cyc=%0d we=%b wa=%h wd=%h rdwe=%b rdd=%h rv=%b rpc=%h dn=%b er=%b required=none",
                                 cyc, csr_we, csr_waddr, csr_wdata, rd_we, rd_data,
                                 redirect_valid, redirect_pc, done, err);
                    end else begin
                        e = exp_q.pop_front();
                        if (a !== e) begin
                            failures++;
                            $display("FAIL event actual: cyc=%0d we=%b wa=%h wd=%h rdwe=%b rdd=%h rv=%b rpc=%h dn=%b er=%b required: cyc=%0d we=%b wa=%h wd=%h rdwe=%b rdd=%h rv=%b rpc=%h dn=%b er=%b",
                                     a.cyc, a.we, a.wa, a.wd, a.rdwe, a.rdd, a.rv, a.rpc, a.dn, a.er,
                                     e.cyc, e.we, e.wa, e.wd, e.rdwe, e.rdd, e.rv, e.rpc, e.dn, e.er);
                        end
                    end
                end else if (csr_waddr != 12'h000 || csr_wdata != 32'h0 ||
                             rd_data != 32'h0 || redirect_pc != 32'h0) begin
                    failures++;
                    $display("FAIL quiet_zero cyc=%0d waddr=%h wdata=%h rd_data=%h redirect_pc=%h required=all zero",
                             cyc, csr_waddr, csr_wdata, rd_data, redirect_pc);
                end
            end
        end
    end

    // Present a request, wait (bounded) for req_ready, check how long that took.
    task automatic issue(input logic [1:0] t, input logic [1:0] op, input logic [11:0] ad,
                         input logic [W-1:0] src, input logic [W-1:0] pc, input logic [7:0] no,
                         input int exp_wait, output int acc);
        int waits;
        waits = 0;
        acc = -1;
        @(negedge clk);
        req_type = t; csr_op = op; csr_addr = ad; csr_src = src;
        req_pc = pc; ecall_no = no; req_valid = 1'b1;
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        checks++;
        if (!req_ready) begin
            failures++;
            $display("FAIL accept_timeout waited=%0d required=req_ready", waits);
        end else begin
            acc = cyc + 1;
            if (waits != exp_wait) begin
                failures++;
                $display("FAIL accept_wait actual=%0d required=%0d", waits, exp_wait);
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_type = 2'b11; csr_op = 2'b00; csr_addr = 12'hFFF;
        csr_src = 32'hFFFF_FFFF; req_pc = 32'hFFFF_FFFF; ecall_no = 8'hFF;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (req_ready !== 1'b1 || csr_we !== 1'b0 || rd_we !== 1'b0 ||
            redirect_valid !== 1'b0 || done !== 1'b0 || err !== 1'b0 || csr_raddr !== 12'h000) begin
            failures++;
            $display("FAIL %s ready=%b we=%b rdwe=%b rv=%b dn=%b er=%b raddr=%h required ready=1 rest 0",
                     name, req_ready, csr_we, rd_we, redirect_valid, done, err, csr_raddr);
        end
    endtask

    task automatic check_val(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    initial begin
        int a;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset_state");

        // CSR RW on MTVEC holding 0
        issue(2'b00, 2'b01, 12'h305, 32'h8000_0100, 32'h0, 8'h00, 0, a);
        exp_q.push_back(mk(a+1, 1'b1, 12'h305, 32'h8000_0100, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0));
        // RS with zero mask on MCAUSE holding 0xB: no write, back-to-back accept
        issue(2'b00, 2'b10, 12'h342, 32'h0, 32'h0, 8'h00, 2, a);
        exp_q.push_back(mk(a+1, 1'b0, 12'h000, 32'h0, 1'b1, 32'hB, 1'b0, 32'h0, 1'b1, 1'b0));
        // RC mask 0x3 on 0xB -> 0x8
        issue(2'b00, 2'b11, 12'h342, 32'h3, 32'h0, 8'h00, 2, a);
        exp_q.push_back(mk(a+1, 1'b1, 12'h342, 32'h8, 1'b1, 32'hB, 1'b0, 32'h0, 1'b1, 1'b0));
        // MTVEC <- 0x80000103
        issue(2'b00, 2'b01, 12'h305, 32'h8000_0103, 32'h0, 8'h00, 2, a);
        exp_q.push_back(mk(a+1, 1'b1, 12'h305, 32'h8000_0103, 1'b1, 32'h8000_0100, 1'b0, 32'h0, 1'b1, 1'b0));
        // ECALL: MEPC, MCAUSE, then aligned vector
        issue(2'b01, 2'b00, 12'h000, 32'h0, 32'h8000_0040, 8'h0B, 2, a);
        exp_q.push_back(mk(a,   1'b1, 12'h341, 32'h8000_0040, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0));
        exp_q.push_back(mk(a+1, 1'b1, 12'h342, 32'h0000_000B, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0));
        exp_q.push_back(mk(a+2, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8000_0100, 1'b1, 1'b0));
        // MEPC <- 0x80000044
        issue(2'b00, 2'b01, 12'h341, 32'h8000_0044, 32'h0, 8'h00, 3, a);
        exp_q.push_back(mk(a+1, 1'b1, 12'h341, 32'h8000_0044, 1'b1, 32'h8000_0040, 1'b0, 32'h0, 1'b1, 1'b0));
        // MRET
        issue(2'b10, 2'b00, 12'h000, 32'h0, 32'h0, 8'h00, 2, a);
        exp_q.push_back(mk(a, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8000_0044, 1'b1, 1'b0));
        // RS nonzero mask on MTVEC
        issue(2'b00, 2'b10, 12'h305, 32'h10, 32'h0, 8'h00, 1, a);
        exp_q.push_back(mk(a+1, 1'b1, 12'h305, 32'h8000_0113, 1'b1, 32'h8000_0103, 1'b0, 32'h0, 1'b1, 1'b0));
        // CSR op 00 is illegal
        issue(2'b00, 2'b00, 12'h305, 32'h5, 32'h0, 8'h00, 2, a);
        exp_q.push_back(mk(a, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1));
        // Reserved request type
        issue(2'b11, 2'b01, 12'h305, 32'h5, 32'h0, 8'h00, 1, a);
        exp_q.push_back(mk(a, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1));

        // ECALL aborted by reset during TR_CAUSE: MEPC stays written, MCAUSE untouched
        issue(2'b01, 2'b00, 12'h000, 32'h0, 32'h8000_0200, 8'h22, 1, a);
        exp_q.push_back(mk(a, 1'b1, 12'h341, 32'h8000_0200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_val("mcause_after_abort", csr_mem[12'h342], 32'h0000_000B);
        check_val("mepc_after_abort", csr_mem[12'h341], 32'h8000_0200);
        check_val("queue_after_abort", exp_q.size(), 32'h0);
        @(negedge clk);
        check_idle("after_abort_release");

        // Normal operation after reset
        issue(2'b00, 2'b01, 12'h305, 32'h1, 32'h0, 8'h00, 0, a);
        exp_q.push_back(mk(a+1, 1'b1, 12'h305, 32'h1, 1'b1, 32'h8000_0113, 1'b0, 32'h0, 1'b1, 1'b0));

        repeat (4) @(negedge clk);
        check_val("queue_drained", exp_q.size(), 32'h0);
        check_val("mtvec_final", csr_mem[12'h305], 32'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached required=finish");
        $fatal(1, "timeout");
    end

endmodule
